// File: rtl/io_bus_arbiter.sv
// Two-requester arbiter onto the memory-mapped IO bus. It issues one command
// at a time and returns read data to the requester that owns it.
// Optional build macro: IO_ARB_FIXED_PRIORITY_EN (requester 0 always wins ties).
module io_bus_arbiter #(
  parameter int READ_LATENCY = 2
) (
  input  logic        main_clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic [15:0] data_out_io,
  input  logic [15:0] data_in_io,
  output logic [31:0] address_io,
  output logic [1:0]  control_io
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic [1:0] CTRL_IDLE  = 2'b00;
  localparam logic [1:0] CTRL_READ  = 2'b01;
  localparam logic [1:0] CTRL_WRITE = 2'b10;
  localparam logic [3:0] LAT_LOAD   = 4'(READ_LATENCY);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;
  logic [1:0]  control_q, control_d;
  logic [31:0] address_q, address_d;
  logic [15:0] dout_q, dout_d;
  logic        any_req_s;
  logic        winner_s;
  logic        ack0_s, ack1_s;

  // Winner selection among the currently requesting masters.
  always_comb begin
    any_req_s = req0 | req1;
    if (req0 && req1) begin
`ifdef IO_ARB_FIXED_PRIORITY_EN
      winner_s = 1'b0;
`else
      winner_s = ~last_grant_q;
`endif
    end else if (req1) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // Next-state and output decode; the bus command fields are latched on grant
  // and shown only for the single ISSUE cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    control_d    = CTRL_IDLE;
    address_d    = 32'h0000_0000;
    dout_d       = 16'h0000;
    ack0_s       = 1'b0;
    ack1_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          owner_d      = winner_s;
          last_grant_d = winner_s;
          we_d         = winner_s ? we1 : we0;
          control_d    = we_d ? CTRL_WRITE : CTRL_READ;
          address_d    = winner_s ? addr1 : addr0;
          dout_d       = winner_s ? wdata1 : wdata0;
          ack0_s       = ~winner_s;
          ack1_s       = winner_s;
          state_d      = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Count 1 marks the cycle whose closing edge samples the bus data.
        if (cnt_q == 4'd1) begin
          if (owner_q) begin
            rdata1_d  = data_in_io;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = data_in_io;
            rvalid0_d = 1'b1;
          end
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge main_clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= 4'd0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= 16'h0000;
      rdata1_q     <= 16'h0000;
      control_q    <= CTRL_IDLE;
      address_q    <= 32'h0000_0000;
      dout_q       <= 16'h0000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      control_q    <= control_d;
      address_q    <= address_d;
      dout_q       <= dout_d;
    end
  end

  // Ack is the grant decision itself, so it is suppressed while reset is held.
  assign ack0        = ack0_s & reset_n;
  assign ack1        = ack1_s & reset_n;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign control_io  = control_q;
  assign address_io  = address_q;
  assign data_out_io = dout_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: transaction-level timing model
// (grant cycle arithmetic) with directed and random requester traffic.
module tb_io_bus_arbiter;
  localparam int LAT  = 2;
  localparam int NSZ  = 700;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [15:0] wdata;
  } txn_t;

  logic main_clk = 1'b0;
  always #6 main_clk = ~main_clk;

  logic        reset_n, req0, req1, we0, we1;
  logic [31:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1, data_out_io, data_in_io;
  logic [31:0] address_io;
  logic [1:0]  control_io;

  logic        b_req0, b_we0;
  logic [31:0] b_addr0;
  logic [15:0] b_wdata0;
  logic        b_ack0, b_ack1, b_rvalid0, b_rvalid1;
  logic [15:0] b_rdata0, b_rdata1, b_data_out_io, b_data_in_io;
  logic [31:0] b_address_io;
  logic [1:0]  b_control_io;

  io_bus_arbiter #(.READ_LATENCY(LAT)) dut (
    .main_clk(main_clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .data_out_io(data_out_io),
    .data_in_io(data_in_io), .address_io(address_io), .control_io(control_io)
  );

  io_bus_arbiter #(.READ_LATENCY(1)) dut_l1 (
    .main_clk(main_clk), .reset_n(reset_n),
    .req0(b_req0), .req1(1'b0), .we0(b_we0), .we1(1'b0),
    .addr0(b_addr0), .addr1(32'h0000_0000), .wdata0(b_wdata0), .wdata1(16'h0000),
    .ack0(b_ack0), .ack1(b_ack1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
    .rdata0(b_rdata0), .rdata1(b_rdata1), .data_out_io(b_data_out_io),
    .data_in_io(b_data_in_io), .address_io(b_address_io), .control_io(b_control_io)
  );

  function automatic logic [15:0] mem_val(input logic [31:0] a);
    case (a)
      32'h0000_1000: mem_val = 16'hBEEF;
      32'h0000_0010: mem_val = 16'hAAAA;
      32'h0000_0012: mem_val = 16'h5555;
      default:       mem_val = a[15:0] ^ 16'hC3A5;
    endcase
  endfunction

  // memory_io models: data is valid only in the cycle whose end is the sample edge.
  int          rem_a = 0, rem_b = 0;
  logic [31:0] rd_addr_a = 32'h0, rd_addr_b = 32'h0;
  always @(posedge main_clk) begin
    if (control_io == 2'b01) begin
      rem_a <= LAT; rd_addr_a <= address_io;
    end else if (rem_a > 0) rem_a <= rem_a - 1;
    if (b_control_io == 2'b01) begin
      rem_b <= 1; rd_addr_b <= b_address_io;
    end else if (rem_b > 0) rem_b <= rem_b - 1;
  end
  assign data_in_io   = (rem_a == 1) ? mem_val(rd_addr_a) : ~mem_val(rd_addr_a);
  assign b_data_in_io = (rem_b == 1) ? mem_val(rd_addr_b) : ~mem_val(rd_addr_b);

  int checks = 0, errors = 0;
  int cyc = 0, free_at = 1;
  logic m_last = 1'b1;
  logic hold_on = 1'b1, rst_now = 1'b0, clr_hold = 1'b0;
  logic raised0 = 1'b0, raised1 = 1'b0;
  txn_t q0[$], q1[$];
  logic [1:0]  exp_ctrl [NSZ];
  logic [31:0] exp_addr [NSZ];
  logic [15:0] exp_dout [NSZ];
  logic        exp_rv0 [NSZ], exp_rv1 [NSZ];
  logic [15:0] exp_rd0 [NSZ], exp_rd1 [NSZ];
  logic [15:0] hold0 = 16'h0, hold1 = 16'h0;
  int n_ack0 = 0, n_ack1 = 0, last_ack0_cyc = -1, last_ack1_cyc = -1, last_rv0_cyc = -1;
  int obs_grants[$];
  logic b_mode = 1'b0;
  int b_acks = 0;
  int b_ack_cyc[2];
  int b_rv_cyc[$];
  logic [15:0] b_rv_dat[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we = 1'($urandom_range(0, 1));
    t.addr = $urandom;
    t.wdata = 16'($urandom);
    return t;
  endfunction

  // One clock cycle: drive requesters, then evaluate the model and compare.
  task automatic tick();
    logic win, e_ack0, e_ack1;
    txn_t t;
    @(posedge main_clk);
    cyc++;
    #1;
    reset_n = !rst_now;
    if (!raised0 && q0.size() > 0 && (hold_on || $urandom_range(0, 2) != 0)) raised0 = 1'b1;
    if (!raised1 && q1.size() > 0 && (hold_on || $urandom_range(0, 2) != 0)) raised1 = 1'b1;
    req0 = raised0;
    req1 = raised1;
    if (raised0) begin we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata; end
    else begin we0 = 1'($urandom_range(0, 1)); addr0 = $urandom; wdata0 = 16'($urandom); end
    if (raised1) begin we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata; end
    else begin we1 = 1'($urandom_range(0, 1)); addr1 = $urandom; wdata1 = 16'($urandom); end
    b_req0 = b_mode && (b_acks < 2);
    b_we0 = 1'b0;
    b_addr0 = (b_acks == 0) ? 32'h0000_0010 : 32'h0000_0012;
    b_wdata0 = 16'h0000;
    @(negedge main_clk);
    if (clr_hold) begin hold0 = 16'h0; hold1 = 16'h0; clr_hold = 1'b0; end
    if (exp_rv0[cyc]) hold0 = exp_rd0[cyc];
    if (exp_rv1[cyc]) hold1 = exp_rd1[cyc];
    e_ack0 = 1'b0;
    e_ack1 = 1'b0;
    if (!rst_now && cyc >= free_at && (raised0 || raised1)) begin
      if (raised0 && raised1) begin
`ifdef IO_ARB_FIXED_PRIORITY_EN
        win = 1'b0;
`else
        win = !m_last;
`endif
      end else win = raised1;
      m_last = win;
      if (win) begin t = q1.pop_front(); raised1 = 1'b0; e_ack1 = 1'b1; end
      else begin t = q0.pop_front(); raised0 = 1'b0; e_ack0 = 1'b1; end
      exp_ctrl[cyc+1] = t.we ? 2'b10 : 2'b01;
      exp_addr[cyc+1] = t.addr;
      exp_dout[cyc+1] = t.wdata;
      if (t.we) free_at = cyc + 2;
      else begin
        free_at = cyc + 2 + LAT;
        if (win) begin exp_rv1[free_at] = 1'b1; exp_rd1[free_at] = mem_val(t.addr); end
        else begin exp_rv0[free_at] = 1'b1; exp_rd0[free_at] = mem_val(t.addr); end
      end
    end
    chk("ack0", ack0, e_ack0);
    chk("ack1", ack1, e_ack1);
    chk("control_io", control_io, exp_ctrl[cyc]);
    chk("address_io", address_io, exp_addr[cyc]);
    chk("data_out_io", data_out_io, exp_dout[cyc]);
    chk("rvalid0", rvalid0, exp_rv0[cyc]);
    chk("rvalid1", rvalid1, exp_rv1[cyc]);
    chk("rdata0", rdata0, hold0);
    chk("rdata1", rdata1, hold1);
    chk("l1_rvalid1", b_rvalid1, 1'b0);
    if (ack0 === 1'b1) begin n_ack0++; last_ack0_cyc = cyc; obs_grants.push_back(0); end
    if (ack1 === 1'b1) begin n_ack1++; last_ack1_cyc = cyc; obs_grants.push_back(1); end
    if (rvalid0 === 1'b1) last_rv0_cyc = cyc;
    if (b_ack0 === 1'b1) begin
      if (b_acks < 2) b_ack_cyc[b_acks] = cyc;
      b_acks++;
    end
    if (b_rvalid0 === 1'b1) begin b_rv_cyc.push_back(cyc); b_rv_dat.push_back(b_rdata0); end
    if (rst_now) begin
      for (int i = cyc + 1; i < NSZ; i++) begin
        exp_ctrl[i] = 2'b00; exp_addr[i] = 32'h0; exp_dout[i] = 16'h0;
        exp_rv0[i] = 1'b0; exp_rv1[i] = 1'b0;
      end
      free_at = cyc + 1;
      m_last = 1'b1;
      clr_hold = 1'b1;
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || raised0 || raised1 || cyc < free_at) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout cycle %0d: observed busy expected idle within %0d", cyc, budget);
    end
  endtask

  initial begin
    int g, rc, n;
    for (int i = 0; i < NSZ; i++) begin
      exp_ctrl[i] = 2'b00; exp_addr[i] = 32'h0; exp_dout[i] = 16'h0;
      exp_rv0[i] = 1'b0; exp_rv1[i] = 1'b0; exp_rd0[i] = 16'h0; exp_rd1[i] = 16'h0;
    end
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h0; addr1 = 32'h0; wdata0 = 16'h0; wdata1 = 16'h0;
    b_req0 = 1'b0; b_we0 = 1'b0; b_addr0 = 32'h0; b_wdata0 = 16'h0;
    repeat (2) @(posedge main_clk);
    @(negedge main_clk);
    chk("rst_ack0", ack0, 1'b0);
    chk("rst_ack1", ack1, 1'b0);
    chk("rst_rvalid0", rvalid0, 1'b0);
    chk("rst_rvalid1", rvalid1, 1'b0);
    chk("rst_rdata0", rdata0, 16'h0);
    chk("rst_rdata1", rdata1, 16'h0);
    chk("rst_control", control_io, 2'b00);
    chk("rst_address", address_io, 32'h0);
    chk("rst_data_out", data_out_io, 16'h0);

    // Single read from requester 0 straight after reset.
    q0.push_back('{1'b0, 32'h0000_1000, 16'h0000});
    run_until_idle(20);
    chk("first_ack0_cycle", last_ack0_cyc, 1);
    chk("first_rvalid0_cycle", last_rv0_cyc, 5);
    chk("first_rdata0", rdata0, 16'hBEEF);

    // Single write from requester 1.
    q1.push_back('{1'b1, 32'h0000_2004, 16'h1234});
    run_until_idle(20);
    chk("write_ack1_count", n_ack1, 1);

    // Both requesters stream writes.
    obs_grants.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b1, 32'h0000_4000 + 32'(i), 16'(16'h0A00 + i)});
      q1.push_back('{1'b1, 32'h0000_5000 + 32'(i), 16'(16'h0B00 + i)});
    end
    run_until_idle(40);
    chk("contend_grant_count", obs_grants.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < obs_grants.size()) begin
`ifdef IO_ARB_FIXED_PRIORITY_EN
        chk("contend_grant_order", obs_grants[i], (i < 4) ? 0 : 1);
`else
        chk("contend_grant_order", obs_grants[i], i % 2);
`endif
      end
    end

    // Reset in the last WAIT cycle of a read drops it.
    n = n_ack0;
    q0.push_back('{1'b0, 32'h0000_3000, 16'h0000});
    g = 0;
    while (n_ack0 == n && g < 10) begin tick(); g++; end
    chk("mid_read_ack0_seen", n_ack0, n + 1);
    tick();
    tick();
    rst_now = 1'b1;
    tick();
    rst_now = 1'b0;
    rc = cyc;
    tick();
    chk("post_reset_rdata0", rdata0, 16'h0);
    chk("post_reset_rvalid0", rvalid0, 1'b0);
    q1.push_back('{1'b1, 32'h0000_6000, 16'h7777});
    run_until_idle(20);
    chk("post_reset_grant_cycle", last_ack1_cyc, rc + 2);

    // Random traffic from both requesters.
    hold_on = 1'b0;
    for (int i = 0; i < 250; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(rand_txn());
      if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(rand_txn());
      tick();
    end
    run_until_idle(80);

    // Back-to-back reads on the READ_LATENCY = 1 instance.
    b_mode = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    b_mode = 1'b0;
    tick();
    chk("l1_ack_count", b_acks, 2);
    chk("l1_rvalid_count", b_rv_cyc.size(), 2);
    if (b_acks >= 2 && b_rv_cyc.size() >= 2) begin
      chk("l1_rvalid_latency_0", b_rv_cyc[0] - b_ack_cyc[0], 3);
      chk("l1_rvalid_latency_1", b_rv_cyc[1] - b_ack_cyc[1], 3);
      chk("l1_ack_spacing", b_ack_cyc[1] - b_ack_cyc[0], 3);
      chk("l1_rdata_0", b_rv_dat[0], 16'hAAAA);
      chk("l1_rdata_1", b_rv_dat[1], 16'h5555);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
